// File: rtl/fsm_seq_pkg.sv
// fsm_seq shared types and helpers.
// State encoding and gap counter sizing.
package fsm_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Gap counter needs to hold GAP_LEN-1; never narrower than 1 bit.
    function automatic int gap_cnt_w(input int gap_len);
        if (gap_len < 1) return 1;
        return $clog2(gap_len + 1);
    endfunction

endpackage

// File: rtl/fsm_seq_cnt.sv
// Loadable down-counter with terminal-count flag.
// Holds at zero; only a load moves it off zero.
module fsm_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Load has priority; decrement stops at zero so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/fsm_seq.sv
// Programmable control-pulse sequencer.
// Pulses ctl for go_len cycles, rep+1 times, with fixed gaps.
module fsm_seq
    import fsm_seq_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int REP_W    = 4,
    parameter int GAP_LEN  = 2,
    parameter int ACK_MODE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   go_len,
    input  logic [REP_W-1:0]   rep,
    input  logic               abort,
    input  logic               done_ack,
    output logic               ctl,
    output logic               done,
    output logic               busy,
    output logic               err,
    output logic [STATE_W-1:0] state_o
);

    localparam int GW = gap_cnt_w(GAP_LEN);
    localparam logic [GW-1:0] GAP_LOAD =
        (GAP_LEN > 0) ? GW'(GAP_LEN - 1) : '0;

    state_t             state;
    state_t             nxt;
    logic [CNT_W-1:0]   len_q;
    logic [REP_W-1:0]   rep_cnt;
    logic               len_tc;
    logic               gap_tc;
    logic               len_load;
    logic [CNT_W-1:0]   len_val;
    logic               gap_load;
    logic               rep_dec;
    logic               accept;

    assign accept = (state == IDLE) && start && (go_len != '0);

    fsm_seq_cnt #(.W(CNT_W)) u_len (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (len_load),
        .en       (state == GO),
        .load_val (len_val),
        .tc       (len_tc)
    );

    fsm_seq_cnt #(.W(GW)) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .en       (state == GAP),
        .load_val (GAP_LOAD),
        .tc       (gap_tc)
    );

    // Next state plus counter load / repeat-decrement strobes.
    always_comb begin
        nxt      = state;
        len_load = 1'b0;
        len_val  = go_len - CNT_W'(1);
        gap_load = 1'b0;
        rep_dec  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nxt      = GO;
                    len_load = 1'b1;
                end
            end
            GO: begin
                if (abort) begin
                    nxt = IDLE;
                end else if (len_tc) begin
                    if (rep_cnt == '0) begin
                        nxt = DONE;
                    end else if (GAP_LEN > 0) begin
                        nxt      = GAP;
                        gap_load = 1'b1;
                    end else begin
                        len_load = 1'b1;
                        len_val  = len_q - CNT_W'(1);
                        rep_dec  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    nxt = IDLE;
                end else if (gap_tc) begin
                    nxt      = GO;
                    len_load = 1'b1;
                    len_val  = len_q - CNT_W'(1);
                    rep_dec  = 1'b1;
                end
            end
            DONE: begin
                if (abort || ACK_MODE == 0 || done_ack) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // State register, latched sequence fields and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_q   <= '0;
            rep_cnt <= '0;
            ctl     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= nxt;
            ctl   <= (nxt == GO);
            done  <= (nxt == DONE);
            busy  <= (nxt != IDLE);
            err   <= (state == IDLE) && start && (go_len == '0);
            if (accept) begin
                len_q   <= go_len;
                rep_cnt <= rep;
            end else if (rep_dec) begin
                rep_cnt <= rep_cnt - REP_W'(1);
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_fsm_seq.sv
// fsm_seq bench: three configurations share one stimulus stream.
// Each is compared every cycle with a sequence-position model.
module tb_fsm_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       done_ack;
    logic [7:0] go_len;
    logic [3:0] rep;

    logic [2:0]      ctl;
    logic [2:0]      done;
    logic [2:0]      busy;
    logic [2:0]      err;
    logic [2:0][1:0] st;

    int GAPS [3] = '{2, 0, 2};
    int ACKS [3] = '{0, 0, 1};

    // model: mode 0 idle, 1 running, 2 done
    int mode [3];
    int pos  [3];
    int tot  [3];
    int mlen [3];
    bit merr [3];

    int n_assert = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fsm_seq #(.GAP_LEN(2), .ACK_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .go_len(go_len),
        .rep(rep), .abort(abort), .done_ack(done_ack),
        .ctl(ctl[0]), .done(done[0]), .busy(busy[0]),
        .err(err[0]), .state_o(st[0])
    );

    fsm_seq #(.GAP_LEN(0), .ACK_MODE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .go_len(go_len),
        .rep(rep), .abort(abort), .done_ack(done_ack),
        .ctl(ctl[1]), .done(done[1]), .busy(busy[1]),
        .err(err[1]), .state_o(st[1])
    );

    fsm_seq #(.GAP_LEN(2), .ACK_MODE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .go_len(go_len),
        .rep(rep), .abort(abort), .done_ack(done_ack),
        .ctl(ctl[2]), .done(done[2]), .busy(busy[2]),
        .err(err[2]), .state_o(st[2])
    );

    function automatic logic [5:0] model_exp(input int i);
        logic       in_go;
        logic [1:0] st_e;
        in_go = 1'b0;
        st_e  = 2'd0;
        if (mode[i] == 1) begin
            in_go = (pos[i] % (mlen[i] + GAPS[i])) < mlen[i];
            st_e  = in_go ? 2'd1 : 2'd2;
        end else if (mode[i] == 2) begin
            st_e = 2'd3;
        end
        return {st_e, merr[i], mode[i] != 0, mode[i] == 2, in_go};
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mode[i] = 0;
                merr[i] = 1'b0;
            end else begin
                merr[i] = 1'b0;
                case (mode[i])
                    0: begin
                        if (start && go_len != 0) begin
                            mlen[i] = int'(go_len);
                            tot[i]  = (int'(rep) + 1) * mlen[i]
                                    + int'(rep) * GAPS[i];
                            pos[i]  = 0;
                            mode[i] = 1;
                        end else if (start) begin
                            merr[i] = 1'b1;
                        end
                    end
                    1: begin
                        if (abort) begin
                            mode[i] = 0;
                        end else begin
                            pos[i]++;
                            if (pos[i] == tot[i]) mode[i] = 2;
                        end
                    end
                    default: begin
                        if (abort || ACKS[i] == 0 || done_ack)
                            mode[i] = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [5:0] obs;
        logic [5:0] expv;
        for (int i = 0; i < 3; i++) begin
            obs  = {st[i], err[i], busy[i], done[i], ctl[i]};
            expv = model_exp(i);
            n_assert++;
            assert (obs === expv) else begin
                n_fail++;
                $error("FAIL %s u%0d t=%0t observed=%b expected=%b",
                       tag, i, $time, obs, expv);
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic a,
                        input logic k, input logic [7:0] gl,
                        input logic [3:0] rp, input string tag);
        rst_n    = r;
        start    = s;
        abort    = a;
        done_ack = k;
        go_len   = gl;
        rep      = rp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int j = 0; j < n; j++) step(1, 0, 0, 0, 8'd0, 4'd0, tag);
    endtask

    task automatic ack(input string tag);
        step(1, 0, 0, 1, 8'd0, 4'd0, tag);
        idle(1, tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mode[i] = 0; pos[i] = 0; tot[i] = 0;
            mlen[i] = 1; merr[i] = 1'b0;
        end
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        done_ack = 1'b0; go_len = '0; rep = '0;

        step(0, 0, 0, 0, 8'd0, 4'd0, "reset");
        step(0, 0, 0, 0, 8'd0, 4'd0, "reset");
        idle(2, "post_reset");

        step(1, 1, 0, 0, 8'd3, 4'd0, "single_start");
        idle(6, "single_run");
        ack("single_ack");

        step(1, 1, 0, 0, 8'd2, 4'd2, "gap_start");
        idle(13, "gap_run");
        ack("gap_ack");

        step(1, 1, 0, 0, 8'd4, 4'd1, "b2b_start");
        idle(12, "b2b_run");
        ack("b2b_ack");

        step(1, 1, 0, 0, 8'd10, 4'd0, "abort_start");
        idle(3, "abort_run");
        step(1, 0, 1, 0, 8'd0, 4'd0, "abort_go");
        idle(3, "abort_after");
        step(1, 1, 1, 0, 8'd2, 4'd0, "abort_start_idle");
        idle(4, "abort_start_run");
        ack("abort_start_ack");

        step(1, 1, 0, 0, 8'd1, 4'd0, "ackm_start");
        for (int j = 0; j < 5; j++)
            step(1, 1, 0, 0, 8'd3, 4'd0, "ackm_hold_start");
        step(1, 0, 0, 1, 8'd0, 4'd0, "ackm_ack");
        step(1, 1, 0, 0, 8'd1, 4'd0, "ackm_restart");
        idle(4, "ackm_run");
        ack("ackm_ack2");
        idle(4, "settle");
        ack("settle_ack");

        step(1, 1, 0, 0, 8'd0, 4'd3, "err_start");
        idle(2, "err_after");

        step(1, 1, 0, 0, 8'd5, 4'd1, "rst_start");
        idle(2, "rst_run");
        step(0, 0, 0, 0, 8'd0, 4'd0, "rst_mid_go");
        rst_n = 1'b1;
        #1;
        check_all("rst_async_release");
        idle(3, "rst_after");

        for (int j = 0; j < 600; j++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0,
                 8'($urandom_range(0, 5)),
                 4'($urandom_range(0, 3)),
                 "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
